// File: rtl/serial_mag_comp.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_comp
// Description : Bit-serial WIDTH-bit magnitude comparator. Consumes one a/b
//               bit pair per enabled cycle and reports registered lt/eq/gt
//               once all WIDTH pairs have arrived (MSB-first or LSB-first).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_comp #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         a,
    input  logic                         b,
    input  logic                         e,
    output logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic                         lt,
    output logic                         eq,
    output logic                         gt,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            dlt_q, dlt_d;
    logic            dgt_q, dgt_d;
    logic            lt_q, lt_d;
    logic            eq_q, eq_d;
    logic            gt_q, gt_d;

    // Next-state, bit counting, running decision and result capture.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        dlt_d     = dlt_q;
        dgt_d     = dgt_q;
        lt_d      = lt_q;
        eq_d      = eq_q;
        gt_d      = gt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CMP;
                    bit_cnt_d = '0;
                    dlt_d     = 1'b0;
                    dgt_d     = 1'b0;
                end
            end

            ST_CMP: begin
                if (e) begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (MSB_FIRST) begin
                        // First differing pair is the most significant one; lock it in.
                        if (!dlt_q && !dgt_q && (a != b)) begin
                            dlt_d = ~a & b;
                            dgt_d = a & ~b;
                        end
                    end else begin
                        // Later pairs are more significant, so each difference overrides.
                        if (a != b) begin
                            dlt_d = ~a & b;
                            dgt_d = a & ~b;
                        end
                    end
                    if (bit_cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        lt_d    = dlt_d;
                        gt_d    = dgt_d;
                        eq_d    = ~(dlt_d | dgt_d);
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_d   = ST_CMP;
                    bit_cnt_d = '0;
                    dlt_d     = 1'b0;
                    dgt_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            dlt_q     <= 1'b0;
            dgt_q     <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            dlt_q     <= dlt_d;
            dgt_q     <= dgt_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
        end
    end

    assign ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy    = (state_q == ST_CMP);
    assign done    = (state_q == ST_DONE);
    assign lt      = lt_q;
    assign eq      = eq_q;
    assign gt      = gt_q;
    assign bit_cnt = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comp.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mag_comp
// Description : Self-checking bench. Two WIDTH=4 comparators (MSB-first and
//               LSB-first) share one serial stream; expected results come
//               from plain integer comparison of the reassembled operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mag_comp;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, a, b, e;
    logic m_ready, m_busy, m_done, m_lt, m_eq, m_gt;
    logic l_ready, l_busy, l_done, l_lt, l_eq, l_gt;
    logic [CW-1:0] m_cnt, l_cnt;
    logic [2:0] m_res, l_res;
    logic [2:0] exp_m, exp_l;

    int total = 0;
    int bad   = 0;

    assign m_res = {m_lt, m_eq, m_gt};
    assign l_res = {l_lt, l_eq, l_gt};

    serial_mag_comp #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .e(e),
        .ready(m_ready), .busy(m_busy), .done(m_done),
        .lt(m_lt), .eq(m_eq), .gt(m_gt), .bit_cnt(m_cnt)
    );

    serial_mag_comp #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .e(e),
        .ready(l_ready), .busy(l_busy), .done(l_done),
        .lt(l_lt), .eq(l_eq), .gt(l_gt), .bit_cnt(l_cnt)
    );

    // Stream order: sa[3] is sent first. The MSB-first DUT sees A=sa,
    // the LSB-first DUT sees A=bit-reversed sa.
    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Result encoding {lt,eq,gt} from plain integer comparison.
    function automatic logic [2:0] res_of(input logic [3:0] x, input logic [3:0] y);
        if (x < y)       return 3'b100;
        else if (x == y) return 3'b010;
        else             return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a comparison and stream four bit pairs (optionally with stalls).
    task automatic drive_compare(input logic [3:0] sa, input logic [3:0] sb, input bit stalls);
        start = 1'b1;
        e     = 1'($urandom_range(0, 1));
        a     = 1'($urandom);
        b     = 1'($urandom);
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (stalls) begin
                repeat ($urandom_range(0, 2)) begin
                    e = 1'b0; a = 1'($urandom); b = 1'($urandom);
                    tick();
                end
            end
            a = sa[3-i]; b = sb[3-i]; e = 1'b1;
            tick();
            e = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 1'b0; b = 1'b0; e = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_m = 3'b000; exp_l = 3'b000;
        total++;
        if ({m_ready, m_busy, m_done, m_res} !== 6'b100000 || m_cnt !== 0) begin
            bad++;
            $display("FAIL reset_msb: got rdy/busy/done/res=%b cnt=%0d want 100000 cnt=0",
                     {m_ready, m_busy, m_done, m_res}, m_cnt);
        end
        total++;
        if ({l_ready, l_busy, l_done, l_res} !== 6'b100000 || l_cnt !== 0) begin
            bad++;
            $display("FAIL reset_lsb: got rdy/busy/done/res=%b cnt=%0d want 100000 cnt=0",
                     {l_ready, l_busy, l_done, l_res}, l_cnt);
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] sa, sb;
        sa = 4'b1010; sb = 4'b1001;
        start = 1'b1; e = 1'b1; a = 1'b1; b = 1'b0;
        tick();
        start = 1'b0; e = 1'b0;
        total++;
        if (m_busy !== 1'b1 || m_ready !== 1'b0 || m_cnt !== 0) begin
            bad++;
            $display("FAIL accept: got busy=%b ready=%b cnt=%0d want busy=1 ready=0 cnt=0",
                     m_busy, m_ready, m_cnt);
        end
        for (int i = 0; i < W; i++) begin
            a = sa[3-i]; b = sb[3-i]; e = 1'b1;
            tick();
            e = 1'b0;
            if (i < W - 1) begin
                total++;
                if (m_done !== 1'b0 || m_cnt !== CW'(i + 1) || m_res !== exp_m) begin
                    bad++;
                    $display("FAIL msb_progress[%0d]: got done=%b cnt=%0d res=%b want done=0 cnt=%0d res=%b",
                             i, m_done, m_cnt, m_res, i + 1, exp_m);
                end
            end
        end
        exp_m = res_of(sa, sb);
        exp_l = res_of(rev4(sa), rev4(sb));
        total++;
        if (m_done !== 1'b1 || m_ready !== 1'b1 || m_cnt !== 4 || m_res !== 3'b001) begin
            bad++;
            $display("FAIL msb_done: got done=%b ready=%b cnt=%0d res=%b want done=1 ready=1 cnt=4 res=001",
                     m_done, m_ready, m_cnt, m_res);
        end
        total++;
        if (l_done !== 1'b1 || l_res !== exp_l) begin
            bad++;
            $display("FAIL lsb_done1: got done=%b res=%b want done=1 res=%b", l_done, l_res, exp_l);
        end
        tick();
        total++;
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b1 || m_cnt !== 4 || m_res !== exp_m) begin
            bad++;
            $display("FAIL idle_hold: got done=%b busy=%b ready=%b cnt=%0d res=%b want 0 0 1 4 %b",
                     m_done, m_busy, m_ready, m_cnt, m_res, exp_m);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] sa_t[2];
        logic [3:0] sb_t[2];
        logic [2:0] want_l[2];
        sa_t[0] = 4'b1100; sb_t[0] = 4'b1010; want_l[0] = 3'b100;
        sa_t[1] = 4'b0110; sb_t[1] = 4'b0110; want_l[1] = 3'b010;
        for (int k = 0; k < 2; k++) begin
            drive_compare(sa_t[k], sb_t[k], 1'b0);
            exp_m = res_of(sa_t[k], sb_t[k]);
            exp_l = res_of(rev4(sa_t[k]), rev4(sb_t[k]));
            total++;
            if (l_done !== 1'b1 || l_res !== want_l[k] || l_res !== exp_l) begin
                bad++;
                $display("FAIL lsb_case[%0d]: got done=%b res=%b want done=1 res=%b", k, l_done, l_res, want_l[k]);
            end
            total++;
            if (m_done !== 1'b1 || m_res !== exp_m) begin
                bad++;
                $display("FAIL lsb_case_msb[%0d]: got done=%b res=%b want done=1 res=%b", k, m_done, m_res, exp_m);
            end
        end
    endtask

    task automatic test_stall();
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int k;
        k = 0;
        start = 1'b1; e = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            e = pat[i][0];
            if (e) begin a = 1'b0; b = 1'b1; end
            else begin a = 1'($urandom); b = 1'($urandom); end
            tick();
            if (pat[i] == 1) k++;
            e = 1'b0;
            if (i < 6) begin
                total++;
                if (m_done !== 1'b0 || l_done !== 1'b0 || m_busy !== 1'b1 || m_cnt !== CW'(k) ||
                    l_cnt !== CW'(k) || m_res !== exp_m || l_res !== exp_l) begin
                    bad++;
                    $display("FAIL stall[%0d]: got done=%b/%b cnt=%0d/%0d res=%b/%b want done=0 cnt=%0d res=%b/%b",
                             i, m_done, l_done, m_cnt, l_cnt, m_res, l_res, k, exp_m, exp_l);
                end
            end
        end
        exp_m = 3'b100; exp_l = 3'b100;
        total++;
        if (m_done !== 1'b1 || l_done !== 1'b1 || m_res !== exp_m || l_res !== exp_l || m_cnt !== 4) begin
            bad++;
            $display("FAIL stall_done: got done=%b/%b res=%b/%b cnt=%0d want done=1 res=100/100 cnt=4",
                     m_done, l_done, m_res, l_res, m_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] xa, xb, ya, yb;
        xa = 4'b0101; xb = 4'b0011; ya = 4'b0011; yb = 4'b0011;
        drive_compare(xa, xb, 1'b0);
        exp_m = res_of(xa, xb);
        exp_l = res_of(rev4(xa), rev4(xb));
        total++;
        if (m_done !== 1'b1 || m_res !== exp_m || l_res !== exp_l) begin
            bad++;
            $display("FAIL b2b_first: got done=%b res=%b/%b want done=1 res=%b/%b", m_done, m_res, l_res, exp_m, exp_l);
        end
        start = 1'b1; e = 1'b0;
        tick();
        start = 1'b0;
        total++;
        if (m_busy !== 1'b1 || m_done !== 1'b0 || m_ready !== 1'b0 || m_cnt !== 0 ||
            m_res !== exp_m || l_res !== exp_l) begin
            bad++;
            $display("FAIL b2b_restart: got busy=%b done=%b ready=%b cnt=%0d res=%b/%b want 1 0 0 0 %b/%b",
                     m_busy, m_done, m_ready, m_cnt, m_res, l_res, exp_m, exp_l);
        end
        for (int i = 0; i < W; i++) begin
            a = ya[3-i]; b = yb[3-i]; e = 1'b1;
            tick();
            e = 1'b0;
            if (i < W - 1) begin
                total++;
                if (m_done !== 1'b0 || m_res !== exp_m || l_res !== exp_l) begin
                    bad++;
                    $display("FAIL b2b_hold[%0d]: got done=%b res=%b/%b want done=0 res=%b/%b",
                             i, m_done, m_res, l_res, exp_m, exp_l);
                end
            end
        end
        exp_m = res_of(ya, yb);
        exp_l = res_of(rev4(ya), rev4(yb));
        total++;
        if (m_done !== 1'b1 || m_res !== exp_m || l_res !== exp_l) begin
            bad++;
            $display("FAIL b2b_second: got done=%b res=%b/%b want done=1 res=%b/%b", m_done, m_res, l_res, exp_m, exp_l);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; e = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 1'($urandom); b = 1'($urandom); e = 1'b1;
            tick();
        end
        e = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_m = 3'b000; exp_l = 3'b000;
        total++;
        if (m_ready !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0 || m_res !== 3'b000 || m_cnt !== 0 ||
            l_res !== 3'b000 || l_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got ready=%b busy=%b done=%b/%b res=%b/%b cnt=%0d want 1 0 0/0 000/000 0",
                     m_ready, m_busy, m_done, l_done, m_res, l_res, m_cnt);
        end
        tick();
        total++;
        if (m_done !== 1'b0 || l_done !== 1'b0 || m_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_nodone: got done=%b/%b ready=%b want done=0/0 ready=1", m_done, l_done, m_ready);
        end
        drive_compare(4'b1111, 4'b1111, 1'b1);
        exp_m = 3'b010; exp_l = 3'b010;
        total++;
        if (m_done !== 1'b1 || m_res !== exp_m || l_res !== exp_l) begin
            bad++;
            $display("FAIL rst_fresh: got done=%b res=%b/%b want done=1 res=010/010", m_done, m_res, l_res);
        end
    endtask

    task automatic test_ignored();
        logic [3:0] sa, sb;
        sa = 4'($urandom); sb = 4'($urandom);
        start = 1'b0; e = 1'b0;
        tick();
        repeat (3) begin
            e = 1'b1; a = 1'($urandom); b = 1'($urandom);
            tick();
        end
        e = 1'b0;
        total++;
        if (m_cnt !== 4 || m_ready !== 1'b1 || m_busy !== 1'b0 || m_res !== exp_m) begin
            bad++;
            $display("FAIL idle_e: got cnt=%0d ready=%b busy=%b res=%b want cnt=4 ready=1 busy=0 res=%b",
                     m_cnt, m_ready, m_busy, m_res, exp_m);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = sa[3-i]; b = sb[3-i]; e = 1'b1;
            tick();
        end
        start = 1'b1; e = 1'b0;
        tick();
        total++;
        if (m_busy !== 1'b1 || m_cnt !== 2) begin
            bad++;
            $display("FAIL cmp_start_stall: got busy=%b cnt=%0d want busy=1 cnt=2", m_busy, m_cnt);
        end
        a = sa[1]; b = sb[1]; e = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (m_busy !== 1'b1 || m_cnt !== 3 || m_done !== 1'b0) begin
            bad++;
            $display("FAIL cmp_start_bit: got busy=%b cnt=%0d done=%b want busy=1 cnt=3 done=0", m_busy, m_cnt, m_done);
        end
        a = sa[0]; b = sb[0]; e = 1'b1;
        tick();
        e = 1'b0;
        exp_m = res_of(sa, sb);
        exp_l = res_of(rev4(sa), rev4(sb));
        total++;
        if (m_done !== 1'b1 || m_res !== exp_m || l_res !== exp_l) begin
            bad++;
            $display("FAIL ignored_result: got done=%b res=%b/%b want done=1 res=%b/%b", m_done, m_res, l_res, exp_m, exp_l);
        end
    endtask

    task automatic test_random();
        logic [3:0] sa, sb;
        for (int n = 0; n < 24; n++) begin
            sa = 4'($urandom);
            sb = ($urandom_range(0, 3) == 0) ? sa : 4'($urandom);
            drive_compare(sa, sb, 1'b1);
            exp_m = res_of(sa, sb);
            exp_l = res_of(rev4(sa), rev4(sb));
            total++;
            if (m_done !== 1'b1 || l_done !== 1'b1 || m_cnt !== 4 || m_res !== exp_m || l_res !== exp_l) begin
                bad++;
                $display("FAIL rand[%0d] A=%b B=%b: got done=%b/%b cnt=%0d res=%b/%b want done=1 cnt=4 res=%b/%b",
                         n, sa, sb, m_done, l_done, m_cnt, m_res, l_res, exp_m, exp_l);
            end
            if ($urandom_range(0, 1) == 1) begin
                e = 1'b1; a = 1'($urandom); b = 1'($urandom);
                tick();
                e = 1'b0;
                total++;
                if (m_done !== 1'b0 || m_cnt !== 4 || m_res !== exp_m || l_res !== exp_l) begin
                    bad++;
                    $display("FAIL rand_idle[%0d]: got done=%b cnt=%0d res=%b/%b want done=0 cnt=4 res=%b/%b",
                             n, m_done, m_cnt, m_res, l_res, exp_m, exp_l);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 1'b0; b = 1'b0; e = 1'b0;
        exp_m = 3'b000; exp_l = 3'b000;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Bit-serial multi-bit magnitude comparator.
- Consumes two operands one bit pair per enabled cycle, using the same a/b/e bit interface the single-bit comparator uses, and reports lt/eq/gt once all WIDTH bit pairs are in.
- It is the receiving end of a serial operand stream. It lets narrow or serial datapaths compare WIDTH-bit words without a parallel comparator.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 means bits arrive MSB first; 0 means bits arrive LSB first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begins a comparison; accepted only while ready=1.
- a  input  1  current bit of operand A.
- b  input  1  current bit of operand B.
- e  input  1  bit enable; a/b are consumed on a rising edge where e=1 in state CMP.
- ready  output  1  high in IDLE and DONE; a comparison can be started.
- busy  output  1  high in CMP.
- done  output  1  one-cycle pulse when the result updates.
- lt  output  1  A<B, registered and held.
- eq  output  1  A==B, registered and held.
- gt  output  1  A>B, registered and held.
- bit_cnt  output  $clog2(WIDTH+1)  number of bit pairs consumed in the current comparison.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, ready=1, busy=0, done=0, lt=0, eq=0, gt=0, bit_cnt=0.
  - Reset takes priority over everything else, including in the middle of CMP.
  - A partial comparison is discarded and no done pulse is produced.
- States are IDLE, CMP and DONE.
- IDLE:
  - start=1 → CMP; bit_cnt←0; internal decision flags: dlt←0, dgt←0.
  - e is ignored.
- CMP:
  - start is ignored.
  - On each edge with e=1, bit_cnt increments.
  - MSB_FIRST=1: the first differing bit pair decides. If dlt=dgt=0 and a≠b, set dlt←(~a&b) and dgt←(a&~b). Later bits do not change the decision.
  - MSB_FIRST=0: every differing bit pair overwrites the decision (dlt←~a&b, dgt←a&~b). Equal pairs leave it unchanged, so the last differing bit (the most significant) wins.
  - When the WIDTH-th pair is consumed (e=1 with bit_cnt=WIDTH-1):
    - next state is DONE;
    - on that same edge, outputs take lt←dlt_next, gt←dgt_next, eq←~(dlt_next|dgt_next);
    - done=1 during the following cycle.
  - e=0 cycles stall indefinitely; state, bit_cnt, decision and outputs are unchanged.
- Latency: done asserts exactly one cycle after the edge that consumed the last bit. With continuous e=1 and start accepted at edge k, done is high during the cycle after edge k+WIDTH.
- DONE:
  - Lasts one cycle; done=1, ready=1.
  - start=1 in DONE is accepted: go to CMP with the same clearing as IDLE, so back-to-back comparisons are possible.
  - Otherwise go to IDLE.
- lt/eq/gt:
  - Change only on the result edge or reset.
  - Held through IDLE and the following CMP until the next result.
  - Exactly one of them is high after any completed comparison. All three are 0 only between reset and the first result.
- bit_cnt:
  - Holds WIDTH in DONE and IDLE after a completion.
  - Cleared on start acceptance.
  - Never exceeds WIDTH.
- Consumption rules:
  - e=1 outside CMP never consumes bits.
  - A bit presented with e=1 on the start-accept edge is not consumed; the first bit must come on a later edge.

Test Plan:
- WIDTH=4, MSB_FIRST=1: A=1010, B=1001 with continuous e → done 5 cycles after the start edge; lt=0, eq=0, gt=1; bit_cnt=4.
- WIDTH=4, MSB_FIRST=0, LSB-first stream: A=0011, B=0101 → lt=1, gt=0 (bit2 decides over bit1); A=B=0110 → eq=1.
- Stall: e toggles 1,0,0,1,0,1,1 with A=0000, B=1111 → done only after the 4th enabled bit; lt=1; outputs unchanged during stalls.
- Back-to-back: start held high in the DONE cycle → next comparison begins with no IDLE cycle; previous result held until the new done pulse.
- Reset mid-operation: rst after 2 of 4 bits → next cycle ready=1, lt=eq=gt=0, bit_cnt=0, no done pulse. A fresh compare of A=B=1111 then gives eq=1.
- Ignored inputs: start pulsed during CMP and e=1 in IDLE → no restart, no bit consumption, bit_cnt unaffected.
